ps2_keyboard: RTL and testbench

//  PS/2 keyboard receiver for the memory-mapped keyboard port (address 0x224) of the mammal SoC.

---
 rtl/kbd_pkg.sv | 20 ++
 rtl/ps2_sync_filter.sv | 53 +++++
 rtl/ps2_keyboard.sv | 152 +++++++++++++++
 tb/tb_ps2_keyboard.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame FSM states, scan-code prefixes and key-word bit positions.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } kbd_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam int unsigned VALID_BIT = 15;
    localparam int unsigned OVR_BIT   = 14;
    localparam int unsigned EXT_BIT   = 9;
    localparam int unsigned BRK_BIT   = 8;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, run-length glitch filter and falling-edge strobe
// for one asynchronous PS/2 line; everything resets to the idle-high level.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic             s1_q, s2_q;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_q, fall_d;

    // The filtered level flips only once FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= in_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = filt_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host frame receiver folding F0/E0 prefixes into a 16-bit
// key word {valid, overrun, 4'b0, ext, brk, code} held until acknowledged.
module ps2_keyboard
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        ack,
    output logic [15:0] dout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic c_fall, c_lvl_unused;
    logic d_lvl, d_fall_unused;

    kbd_state_e       state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic [15:0]      dout_q, dout_d;
    logic             frame_good;
    logic             load_word;
    logic             valid_eff;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst     (reset),
        .in_i    (ps2c),
        .level_o (c_lvl_unused),
        .fall_o  (c_fall)
    );

    // Data runs through the same filter so it stays aligned with the clock strobe.
    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .rst     (reset),
        .in_i    (ps2d),
        .level_o (d_lvl),
        .fall_o  (d_fall_unused)
    );

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        frame_good = 1'b0;
        tmo_d      = '0;

        case (state_q)
            IDLE: begin
                if (c_fall && !d_lvl) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (c_fall) begin
                    shift_d  = {d_lvl, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (c_fall) begin
                    par_ok_d = ^{shift_q, d_lvl};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (c_fall) begin
                    frame_good = d_lvl & par_ok_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !c_fall) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign load_word = frame_good && (shift_q != SC_BREAK) && (shift_q != SC_EXT);
    // An ack coinciding with a new word means the old word was consumed: no overrun.
    assign valid_eff = dout_q[VALID_BIT] & ~ack;

    always_comb begin
        brk_d  = brk_q;
        ext_d  = ext_q;
        dout_d = dout_q;
        if (frame_good && shift_q == SC_BREAK) begin
            brk_d = 1'b1;
        end
        if (frame_good && shift_q == SC_EXT) begin
            ext_d = 1'b1;
        end
        if (load_word) begin
            dout_d            = '0;
            dout_d[VALID_BIT] = 1'b1;
            dout_d[OVR_BIT]   = valid_eff;
            dout_d[EXT_BIT]   = ext_q;
            dout_d[BRK_BIT]   = brk_q;
            dout_d[7:0]       = shift_q;
            brk_d             = 1'b0;
            ext_d             = 1'b0;
        end else if (ack) begin
            dout_d[VALID_BIT] = 1'b0;
            dout_d[OVR_BIT]   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_ok_q <= 1'b0;
            tmo_q    <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_ok_q <= par_ok_d;
            tmo_q    <= tmo_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            dout_q   <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames, hand-computed key words.
module tb_ps2_keyboard;

    localparam int HALF = 40;    // PS/2 half period in clk cycles
    localparam int TMO  = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic        ack = 1'b0;
    logic [15:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .ack   (ack),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %04h, expected %04h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_cyc(HALF);
        ps2c = 1'b0;
        wait_cyc(HALF);
        ps2c = 1'b1;
    endtask

    // Full frame; the ack hook fires in the exact cycle the DUT loads a word.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input logic race_ack);
        logic par;
        int   seen;
        par  = ~(^b) ^ bad_par;
        seen = 0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2d = stop;
        wait_cyc(HALF);
        ps2c = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            if (race_ack && seen == 0 && dut.load_word) begin
                ack  = 1'b1;
                seen = 1;
            end else begin
                ack = 1'b0;
            end
        end
        ack  = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        wait_cyc(20);
        if (race_ack) check("race_hook_seen", 16'(seen), 16'd1);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        // Reset with toggling lines
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            ps2c = i[2];
            ps2d = i[1];
            if (i % 20 == 0) check("reset_hold", dout, 16'h0000);
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(100);
        check("reset_idle", dout, 16'h0000);

        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("make_1c", dout, 16'h801C);
        pulse_ack();
        check("ack_1c", dout, 16'h001C);
        pulse_ack();
        check("ack_no_valid", dout, 16'h001C);

        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        check("prefix_e0", dout, 16'h001C);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("prefix_f0", dout, 16'h001C);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        check("ext_break_75", dout, 16'h8375);
        pulse_ack();
        check("ack_75", dout, 16'h0375);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("flags_cleared", dout, 16'h801C);
        pulse_ack();

        send_frame(8'h29, 1'b1, 1'b1, 1'b0);
        check("bad_parity", dout, 16'h001C);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("bad_stop", dout, 16'h001C);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2d = 1'b1;
        wait_cyc(2 * TMO);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("after_timeout", dout, 16'h8029);
        pulse_ack();
        check("ack_29", dout, 16'h0029);

        send_frame(8'h16, 1'b0, 1'b1, 1'b0);
        check("first_16", dout, 16'h8016);
        send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
        check("overrun_1e", dout, 16'hC01E);
        pulse_ack();
        check("ack_clears_ovr", dout, 16'h001E);

        send_frame(8'h16, 1'b0, 1'b1, 1'b0);
        check("race_pre_16", dout, 16'h8016);
        send_frame(8'h1E, 1'b0, 1'b1, 1'b1);
        check("race_1e", dout, 16'h801E);
        pulse_ack();

        // 3-cycle ps2c glitch with data low must not start a frame
        ps2d = 1'b0;
        wait_cyc(20);
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
        wait_cyc(50);
        ps2d = 1'b1;
        wait_cyc(50);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("glitch_then_1c", dout, 16'h801C);

        // Reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        reset = 1'b1;
        wait_cyc(3);
        check("reset_mid_frame", dout, 16'h0000);
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(50);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("after_mid_reset", dout, 16'h8029);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
